muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 208 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M/RV64M multiply/divide unit.
// A single-cycle multiply and a radix-2 restoring divider (XLEN iterations)
// are sequenced by a small FSM behind a start/busy/valid handshake.
// Optional build macro: MULDIV_FAST_SPECIAL_EN. When it is defined,
// divide-by-zero and signed-overflow bypass the divide iterations.
module muldiv_unit #(
  parameter int XLEN = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  // funct3 encodings
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Latched operation context
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic              a_neg_q;
  logic              b_neg_q;
  logic              div0_q;
  logic              ovf_q;

  // Datapath state
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   dvs_q;
  logic [CNT_W-1:0]  cnt_q;

  // Input decode (only meaningful in the acceptance cycle)
  logic              accept;
  logic              div_signed_in;
  logic              a_sgn_in;
  logic              b_sgn_in;
  logic [XLEN-1:0]   a_mag_in;
  logic [XLEN-1:0]   b_mag_in;
  logic              div0_in;
  logic              ovf_in;

  // One restoring-division step
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;

  // Result selection
  logic              q_neg;
  logic              r_neg;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;
  logic [XLEN-1:0]   done_val;

  assign busy   = (state_q != S_IDLE);
  assign accept = start & ~busy & ~kill;

  // For divides the sign only matters for signed ops; for multiplies it
  // selects sign- versus zero-extension of each operand.
  assign div_signed_in = op[2] & ~op[0];
  assign a_sgn_in = op[2] ? (div_signed_in & a[XLEN-1])
                          : ((op[1:0] != 2'b11) & a[XLEN-1]);
  assign b_sgn_in = op[2] ? (div_signed_in & b[XLEN-1])
                          : (~op[1] & b[XLEN-1]);
  assign a_mag_in = a_sgn_in ? -a : a;
  assign b_mag_in = b_sgn_in ? -b : b;
  assign div0_in  = (b == '0);
  assign ovf_in   = div_signed_in & (a == MOST_NEG) & (b == '1);

  // The partial remainder is always below the divisor, so the shifted value
  // fits in XLEN+1 bits and diff[XLEN] is a valid borrow/sign bit.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  assign q_neg = ~op_q[0] & (a_neg_q ^ b_neg_q);
  assign r_neg = ~op_q[0] & a_neg_q;
  assign q_fix = q_neg ? -quo_q : quo_q;
  assign r_fix = r_neg ? -rem_q : rem_q;

  // Final result mux, including the architectural special cases
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    done_val = '0;
    case (op_q)
      OP_MUL:                       done_val = prod_q[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: done_val = prod_q[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div0_q)     done_val = '1;
        else if (ovf_q) done_val = a_q;
        else            done_val = q_fix;
      end
      OP_REM, OP_REMU: begin
        if (div0_q)     done_val = a_q;
        else if (ovf_q) done_val = '0;
        else            done_val = r_fix;
      end
      default:          done_val = '0;
    endcase
  end

  // Next-state logic; kill overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op[2]) begin
`ifdef MULDIV_FAST_SPECIAL_EN
            state_d = (div0_in | ovf_in) ? S_DONE : S_DIV_RUN;
`else
            state_d = S_DIV_RUN;
`endif
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL:     state_d = S_DONE;
      S_DIV_RUN: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Architecturally visible registers: result, valid pulse, iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      valid  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        cnt_q <= CNT_W'(XLEN);
      end else if (state_q == S_DIV_RUN) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_q == S_DONE && !kill) begin
        result <= done_val;
        valid  <= 1'b1;
      end
    end
  end

  // Operand capture and arithmetic datapath
  always_ff @(posedge clk) begin
    // NOTE: these are pure data registers whose contents are only consumed
    // after an acceptance reloads them, so they carry no reset.
    if (accept) begin
      op_q    <= op;
      a_q     <= a;
      b_q     <= b;
      a_neg_q <= a_sgn_in;
      b_neg_q <= b_sgn_in;
      div0_q  <= div0_in;
      ovf_q   <= ovf_in;
      rem_q   <= '0;
      quo_q   <= a_mag_in;
      dvs_q   <= b_mag_in;
    end else if (state_q == S_MUL) begin
      prod_q <= {{XLEN{a_neg_q}}, a_q} * {{XLEN{b_neg_q}}, b_q};
    end else if (state_q == S_DIV_RUN) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven check of muldiv_unit (XLEN=32) plus directed
// sequences for kill, kill+start, back-to-back issue and mid-operation reset.
// Latency below is counted in clock edges from the acceptance edge to the
// edge after which valid is high.
module tb_muldiv_unit;

  localparam int XLEN     = 32;
  localparam int LAT_MUL  = 2;
  localparam int LAT_DIV  = XLEN + 1;
`ifdef MULDIV_FAST_SPECIAL_EN
  localparam int LAT_SPEC = 1;
`else
  localparam int LAT_SPEC = XLEN + 1;
`endif
  localparam int BUDGET   = 100;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .kill  (kill),
    .busy  (busy),
    .valid (valid),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request at the falling edge; returns #1 after the acceptance edge
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~x;  // later operand changes must not matter
    b     = ~y;
  endtask

  // Wait (bounded) for valid; report latency and number of busy cycles
  task automatic wait_done(output logic [31:0] res, output int lat, output int bcnt);
    int k;
    k    = 0;
    bcnt = 0;
    while (!valid && k < BUDGET) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      k++;
    end
    lat = k;
    res = result;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] last_exp;
    int          lat;
    int          bcnt;
    int          vcount;

    rst   = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;

    vecs.push_back('{MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, LAT_MUL});
    vecs.push_back('{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_MUL});
    vecs.push_back('{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MUL});
    vecs.push_back('{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL});
    vecs.push_back('{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT_MUL});
    vecs.push_back('{MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, LAT_MUL});
    vecs.push_back('{MUL,    32'h0000_0003, 32'h0000_0005, 32'h0000_000F, LAT_MUL});
    vecs.push_back('{DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LAT_DIV});
    vecs.push_back('{REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LAT_DIV});
    vecs.push_back('{DIVU,   32'd100,       32'd7,         32'd14,        LAT_DIV});
    vecs.push_back('{REMU,   32'd100,       32'd7,         32'd2,         LAT_DIV});
    vecs.push_back('{DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_DIV});
    vecs.push_back('{REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, LAT_DIV});
    vecs.push_back('{DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, LAT_DIV});
    vecs.push_back('{REMU,   32'hFFFF_FFFF, 32'h10,        32'h0000_000F, LAT_DIV});
    vecs.push_back('{DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_DIV});
    vecs.push_back('{DIV,    32'h8000_0000, 32'd3,         32'hD555_5556, LAT_DIV});
    vecs.push_back('{REM,    32'h8000_0000, 32'd3,         32'hFFFF_FFFE, LAT_DIV});
    vecs.push_back('{DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SPEC});
    vecs.push_back('{REMU,   32'd5,         32'd0,         32'd5,         LAT_SPEC});
    vecs.push_back('{DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SPEC});
    vecs.push_back('{REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, LAT_SPEC});
    vecs.push_back('{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC});
    vecs.push_back('{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_SPEC});

    repeat (3) @(posedge clk);
    #1;
    check("reset busy",   64'(busy),   64'(0));
    check("reset valid",  64'(valid),  64'(0));
    check("reset result", 64'(result), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Consecutive vectors issue in each other's valid cycle (back-to-back)
    last_exp = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(res, lat, bcnt);
      check($sformatf("vec%0d result", i),  64'(res),   64'(vecs[i].exp));
      check($sformatf("vec%0d latency", i), 64'(lat),   64'(vecs[i].lat));
      check($sformatf("vec%0d busy", i),    64'(bcnt),  64'(vecs[i].lat));
      check($sformatf("vec%0d busy_lo", i), 64'(busy),  64'(0));
      last_exp = vecs[i].exp;
    end

    // Kill during DIV_RUN: no valid, busy drops, result untouched
    issue(DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill busy", 64'(busy), 64'(0));
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid) vcount++;
      @(posedge clk);
      #1;
    end
    check("kill no valid", 64'(vcount), 64'(0));
    check("kill result",   64'(result), 64'(last_exp));

    // Kill and start at the same edge: nothing accepted
    @(negedge clk);
    start = 1'b1;
    kill  = 1'b1;
    op    = MUL;
    a     = 32'd3;
    b     = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    kill  = 1'b0;
    check("kill+start busy", 64'(busy), 64'(0));
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      if (valid) vcount++;
      @(posedge clk);
      #1;
    end
    check("kill+start no valid", 64'(vcount), 64'(0));
    check("kill+start result",   64'(result), 64'(last_exp));

    // Start in the valid cycle: old result held until the new DONE
    issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(res, lat, bcnt);
    check("b2b first result", 64'(res), 64'(32'hFFFF_FFFE));
    issue(DIVU, 32'd100, 32'd7);
    check("b2b accepted", 64'(busy),   64'(1));
    check("b2b held",     64'(result), 64'(32'hFFFF_FFFE));
    wait_done(res, lat, bcnt);
    check("b2b second result",  64'(res), 64'(14));
    check("b2b second latency", 64'(lat), 64'(LAT_DIV));

    // Reset in the middle of DIV_RUN
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst busy",   64'(busy),   64'(0));
    check("midrst valid",  64'(valid),  64'(0));
    check("midrst result", 64'(result), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    issue(DIVU, 32'd9, 32'd3);
    wait_done(res, lat, bcnt);
    check("postrst result",  64'(res), 64'(3));
    check("postrst latency", 64'(lat), 64'(LAT_DIV));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
